// File: rtl/mul_pipe_lanes_pkg.sv
// Shared types and constant helpers for the multi-lane pipelined multiplier.
package mul_pkg;

    // Per-transaction arithmetic mode; travels down the pipe with its operands.
    typedef struct packed {
        logic round_en;
        logic sat_en;
    } mul_mode_t;

    // Full signed product width for an a*b multiply.
    function automatic int unsigned prod_width(input int unsigned a, input int unsigned b);
        return a + b;
    endfunction

    // Largest value representable in a w-bit signed result.
    function automatic longint sat_hi(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    // Smallest value representable in a w-bit signed result.
    function automatic longint sat_lo(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/mul_pipe_lanes_if.sv
// Operand/result stream bus of the lane multiplier: one shared valid/ready
// handshake per side, lanes packed side by side in the data vectors.
interface mul_pipe_lanes_if #(
    parameter int unsigned A_WIDTH   = 16,
    parameter int unsigned B_WIDTH   = 16,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned LANES     = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*A_WIDTH-1:0]   in_a;
    logic [LANES*B_WIDTH-1:0]   in_b;
    logic                       round_en;
    logic                       sat_en;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*OUT_WIDTH-1:0] out_data;
    logic [LANES-1:0]           out_ovf;

    // Operand source / result sink side.
    modport master (
        output in_valid, in_a, in_b, round_en, sat_en, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    // Multiplier side.
    modport slave (
        input  in_valid, in_a, in_b, round_en, sat_en, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/mul_pipe_lanes_lane_post.sv
// Per-lane post-processing of a full signed product: optional round-half-up,
// arithmetic right shift, overflow detection and saturate-or-wrap narrowing.
module mul_lane_post
    import mul_pkg::*;
#(
    parameter int unsigned A_WIDTH   = 16,
    parameter int unsigned B_WIDTH   = 16,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned OUT_SCALE = 8,
    localparam int unsigned PW       = prod_width(A_WIDTH, B_WIDTH)
) (
    input  logic signed [PW-1:0]  prod,
    input  mul_mode_t             mode,
    output logic [OUT_WIDTH-1:0]  result,
    output logic                  ovf
);
    // One guard bit so the rounding increment can never wrap.
    localparam int unsigned SW = PW + 1;
    localparam logic signed [SW-1:0] RND =
        (OUT_SCALE > 0) ? (SW'(1) << ((OUT_SCALE > 0) ? OUT_SCALE - 1 : 0)) : '0;
    localparam logic signed [SW-1:0]  HI     = SW'(sat_hi(OUT_WIDTH));
    localparam logic signed [SW-1:0]  LO     = SW'(sat_lo(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0]  HI_OUT = OUT_WIDTH'(sat_hi(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0]  LO_OUT = OUT_WIDTH'(sat_lo(OUT_WIDTH));

    logic signed [SW-1:0] p_ext;
    logic signed [SW-1:0] p_rnd;
    logic signed [SW-1:0] s;

    // Round, floor-shift, range check and narrow.
    always_comb begin
        p_ext = SW'(prod);
        p_rnd = p_ext;
        if (mode.round_en) begin
            p_rnd = p_ext + RND;
        end
        s      = p_rnd >>> OUT_SCALE;
        ovf    = (s > HI) || (s < LO);
        result = s[OUT_WIDTH-1:0];
        if (mode.sat_en) begin
            if (s > HI) begin
                result = HI_OUT;
            end else if (s < LO) begin
                result = LO_OUT;
            end
        end
    end
endmodule

// File: rtl/mul_pipe_lanes.sv
// Multi-lane elastic pipelined signed fixed-point multiplier. With two or more
// stages the raw products are registered first and post-processing sits
// between stage 1 and stage 2; further stages only delay the results.
module mul_pipe_lanes
    import mul_pkg::*;
#(
    parameter int unsigned A_WIDTH   = 16,
    parameter int unsigned B_WIDTH   = 16,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned OUT_SCALE = 8,
    parameter int unsigned LANES     = 4,
    parameter int unsigned STAGES    = 2
) (
    input  logic           clk,
    input  logic           arst_n_in,
    mul_pipe_lanes_if.slave bus
);
    localparam int unsigned PW = prod_width(A_WIDTH, B_WIDTH);
    // Index of the first stage that holds narrowed results.
    localparam int unsigned RS = (STAGES == 1) ? 0 : 1;
    localparam int unsigned NR = STAGES - RS;

    logic signed [PW-1:0]       prod_in   [LANES];
    logic signed [PW-1:0]       post_prod [LANES];
    mul_mode_t                  in_mode;
    mul_mode_t                  post_mode;
    logic [LANES*OUT_WIDTH-1:0] post_res;
    logic [LANES-1:0]           post_ovf;

    logic [STAGES-1:0]          v;
    logic [STAGES-1:0]          v_src;
    logic [STAGES-1:0]          load;

    logic [LANES*OUT_WIDTH-1:0] res_q [NR];
    logic [LANES-1:0]           ovf_q [NR];

    assign in_mode = '{round_en: bus.round_en, sat_en: bus.sat_en};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [A_WIDTH-1:0] a_l;
        logic signed [B_WIDTH-1:0] b_l;
        logic signed [PW-1:0]      a_x;
        logic signed [PW-1:0]      b_x;

        assign a_l        = bus.in_a[i*A_WIDTH +: A_WIDTH];
        assign b_l        = bus.in_b[i*B_WIDTH +: B_WIDTH];
        assign a_x        = PW'(a_l);
        assign b_x        = PW'(b_l);
        assign prod_in[i] = a_x * b_x;

        mul_lane_post #(
            .A_WIDTH  (A_WIDTH),
            .B_WIDTH  (B_WIDTH),
            .OUT_WIDTH(OUT_WIDTH),
            .OUT_SCALE(OUT_SCALE)
        ) u_post (
            .prod  (post_prod[i]),
            .mode  (post_mode),
            .result(post_res[i*OUT_WIDTH +: OUT_WIDTH]),
            .ovf   (post_ovf[i])
        );
    end

    if (STAGES == 1) begin : g_post_direct
        assign post_prod = prod_in;
        assign post_mode = in_mode;
    end else begin : g_prod_stage
        logic signed [PW-1:0] prod_q [LANES];
        mul_mode_t            mode_q;

        // Stage 1 captures raw products and the transaction's modes.
        always_ff @(posedge clk or negedge arst_n_in) begin
            if (!arst_n_in) begin
                prod_q <= '{default: '0};
                mode_q <= '0;
            end else if (load[0] && bus.in_valid) begin
                prod_q <= prod_in;
                mode_q <= in_mode;
            end
        end

        assign post_prod = prod_q;
        assign post_mode = mode_q;
    end

    // Valid feeding each stage: the input handshake or the previous stage.
    always_comb begin
        v_src    = '0;
        v_src[0] = bus.in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            v_src[k] = v[k-1];
        end
    end

    // Stage k may load if any stage from k onward is empty or the sink drains;
    // the ripple chain is flattened into this reduction so no bit depends on another.
    always_comb begin
        load = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            logic acc;
            acc = bus.out_ready;
            for (int unsigned j = k; j < STAGES; j++) begin
                if (!v[j]) begin
                    acc = 1'b1;
                end
            end
            load[k] = acc;
        end
    end

    // Stage valid bits advance wherever the stage is allowed to load.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            v <= '0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    v[k] <= v_src[k];
                end
            end
        end
    end

    // Result stages: first takes the post-processed lanes, the rest shift.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            res_q <= '{default: '0};
            ovf_q <= '{default: '0};
        end else begin
            if (load[RS] && v_src[RS]) begin
                res_q[0] <= post_res;
                ovf_q[0] <= post_ovf;
            end
            for (int unsigned j = 1; j < NR; j++) begin
                if (load[RS+j] && v_src[RS+j]) begin
                    res_q[j] <= res_q[j-1];
                    ovf_q[j] <= ovf_q[j-1];
                end
            end
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = v[STAGES-1];
    assign bus.out_data  = res_q[NR-1];
    assign bus.out_ovf   = ovf_q[NR-1];
endmodule
